// File: rtl/bounce_pkg.sv
// ---------------------------------------------------------------------------
// bounce_pkg
// Shared definitions for the bouncing one-hot sequence decoder:
//   - state_t     : decoder tracking states (SEARCH, ACQUIRE, LOCKED)
//   - pos_width() : width of a binary index into an N-bit one-hot bus
//   - RST_*       : values the decoder returns to on reset
// ---------------------------------------------------------------------------
package bounce_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // A 1-bit index is still needed when N is 2 (or degenerate).
    function automatic int pos_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam state_t RST_STATE  = SEARCH;
    localparam logic   RST_DIR    = 1'b1;
    localparam logic   RST_TC     = 1'b0;
    localparam logic   RST_ERR    = 1'b0;
    localparam int     RST_POS    = 0;
    localparam int     RST_PERIOD = 0;
    localparam int     RST_ERRCNT = 0;

endpackage

// File: rtl/onehot_enc.sv
// ---------------------------------------------------------------------------
// onehot_enc
// Combinational one-hot to binary encoder with a validity flag.
// Ports:
//   i_onehot  in  N  sampled pattern
//   o_idx     out P  index of the set bit (meaningful only when o_valid)
//   o_valid   out 1  exactly one bit of i_onehot is set
// ---------------------------------------------------------------------------
module onehot_enc
    import bounce_pkg::*;
#(
    parameter int N = 8,
    parameter int P = pos_width(N)
) (
    input  logic [N-1:0] i_onehot,
    output logic [P-1:0] o_idx,
    output logic         o_valid
);

    logic [N-1:0] w_minus1;

    // OR-ing the indices of all set bits is exact for a one-hot input; for
    // other inputs the index is garbage but o_valid is low.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | P'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    assign w_minus1 = i_onehot - N'(1);
    assign o_valid  = (i_onehot != '0) && ((i_onehot & w_minus1) == '0);

endmodule

// File: rtl/bounce_decoder.sv
// ---------------------------------------------------------------------------
// bounce_decoder
// Receive-side monitor for a bouncing one-hot pattern. Recovers position and
// sweep direction, locks onto the bounce sequence, pulses tc on every LSB
// arrival while locked, counts periods and flags sequence violations.
//
// Ports:
//   clk           in  1              rising-edge clock
//   rstna         in  1              synchronous active-low reset
//   ena           in  1              q_in carries a new sample this cycle
//   q_in          in  N              observed pattern
//   pos           out P              index of last accepted position
//   dir           out 1              1 = moving toward LSB, 0 = toward MSB
//   locked        out 1              tracking a valid sequence
//   tc            out 1              pulse: LSB reached while locked
//   err           out 1              pulse: sequence violation while locked
//   period_count  out COUNTER_WIDTH  wrapping count of LSB arrivals
//   err_count     out ERR_WIDTH      saturating violation count
//
// Build option: BOUNCE_DEC_ERRCNT_EN enables the err_count counter; when it
// is not defined err_count is tied to zero and has no storage.
// ---------------------------------------------------------------------------
module bounce_decoder
    import bounce_pkg::*;
#(
    parameter int N             = 8,
    parameter int COUNTER_WIDTH = 8,
    parameter int ERR_WIDTH     = 8,
    parameter int P             = pos_width(N)
) (
    input  logic                     clk,
    input  logic                     rstna,
    input  logic                     ena,
    input  logic [N-1:0]             q_in,
    output logic [P-1:0]             pos,
    output logic                     dir,
    output logic                     locked,
    output logic                     tc,
    output logic                     err,
    output logic [COUNTER_WIDTH-1:0] period_count,
    output logic [ERR_WIDTH-1:0]     err_count
);

    localparam logic [P-1:0] POS_MAX = P'(N - 1);
    localparam logic [P:0]   ONE_E   = (P + 1)'(1);

    state_t                   r_state, w_state_nx;
    logic [P-1:0]             r_pos, w_pos_nx;
    logic                     r_dir, w_dir_nx;
    logic                     r_tc, w_tc_nx;
    logic                     r_err, w_err_nx;
    logic [COUNTER_WIDTH-1:0] r_period, w_period_nx;

    logic [P-1:0]             w_idx;
    logic                     w_valid;
    logic [P-1:0]             w_exp_idx;
    logic                     w_exp_dir;
    logic [P:0]               w_idx_e, w_pos_e;
    logic                     w_adjacent;

    onehot_enc #(
        .N (N),
        .P (P)
    ) u_enc (
        .i_onehot (q_in),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    // Expected next position while locked, reflecting at either end.
    always_comb begin
        w_exp_idx = r_pos;
        w_exp_dir = r_dir;
        if (r_dir) begin
            if (r_pos == '0) begin
                w_exp_idx = P'(1);
                w_exp_dir = 1'b0;
            end else begin
                w_exp_idx = r_pos - P'(1);
            end
        end else begin
            if (r_pos == POS_MAX) begin
                w_exp_idx = POS_MAX - P'(1);
                w_exp_dir = 1'b1;
            end else begin
                w_exp_idx = r_pos + P'(1);
            end
        end
    end

    // One extra bit so that pos+1 at the top end cannot wrap into index 0.
    assign w_idx_e    = {1'b0, w_idx};
    assign w_pos_e    = {1'b0, r_pos};
    assign w_adjacent = (w_idx_e == w_pos_e + ONE_E) || (w_pos_e == w_idx_e + ONE_E);

    always_comb begin
        w_state_nx  = r_state;
        w_pos_nx    = r_pos;
        w_dir_nx    = r_dir;
        w_tc_nx     = 1'b0;
        w_err_nx    = 1'b0;
        w_period_nx = r_period;
        if (ena) begin
            case (r_state)
                SEARCH: begin
                    if (w_valid) begin
                        w_pos_nx   = w_idx;
                        w_state_nx = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (!w_valid) begin
                        w_state_nx = SEARCH;
                    end else begin
                        w_pos_nx = w_idx;
                        if (w_adjacent) begin
                            // Locking never raises tc, even when landing on 0.
                            w_dir_nx   = (w_idx < r_pos);
                            w_state_nx = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (w_valid && (w_idx == w_exp_idx)) begin
                        w_pos_nx = w_idx;
                        w_dir_nx = w_exp_dir;
                        if (w_idx == '0) begin
                            w_tc_nx     = 1'b1;
                            w_period_nx = r_period + COUNTER_WIDTH'(1);
                        end
                    end else begin
                        w_err_nx = 1'b1;
                        if (w_valid) begin
                            w_pos_nx   = w_idx;
                            w_state_nx = ACQUIRE;
                        end else begin
                            w_state_nx = SEARCH;
                        end
                    end
                end
                default: begin
                    w_state_nx = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstna) begin
            r_state  <= RST_STATE;
            r_pos    <= P'(RST_POS);
            r_dir    <= RST_DIR;
            r_tc     <= RST_TC;
            r_err    <= RST_ERR;
            r_period <= COUNTER_WIDTH'(RST_PERIOD);
        end else begin
            r_state  <= w_state_nx;
            r_pos    <= w_pos_nx;
            r_dir    <= w_dir_nx;
            r_tc     <= w_tc_nx;
            r_err    <= w_err_nx;
            r_period <= w_period_nx;
        end
    end

`ifdef BOUNCE_DEC_ERRCNT_EN
    logic [ERR_WIDTH-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (!rstna) begin
            r_err_count <= ERR_WIDTH'(RST_ERRCNT);
        end else if (w_err_nx && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_WIDTH'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign pos          = r_pos;
    assign dir          = r_dir;
    assign locked       = (r_state == LOCKED);
    assign tc           = r_tc;
    assign err          = r_err;
    assign period_count = r_period;

endmodule

// File: tb/tb_bounce_decoder.sv
// ---------------------------------------------------------------------------
// tb_bounce_decoder
// Scoreboard bench: the driver applies a sample on the falling edge and
// pushes the reference model's prediction; the monitor pops and compares
// just after each rising edge.
// ---------------------------------------------------------------------------
module tb_bounce_decoder;

    localparam int N  = 8;
    localparam int CW = 2;
    localparam int EW = 2;
    localparam int P  = 3;
`ifdef BOUNCE_DEC_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    typedef struct packed {
        logic [P-1:0]  pos;
        logic          dir;
        logic          locked;
        logic          tc;
        logic          err;
        logic [CW-1:0] per;
        logic [EW-1:0] ec;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstna;
    logic          ena;
    logic [N-1:0]  q_in;
    logic [P-1:0]  pos;
    logic          dir, locked, tc, err;
    logic [CW-1:0] period_count;
    logic [EW-1:0] err_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Reference model state: 0 searching, 1 acquiring, 2 locked.
    int mstate = 0, mpos = 0, mdir = 1, mper = 0, merr = 0;

    bounce_decoder #(
        .N             (N),
        .COUNTER_WIDTH (CW),
        .ERR_WIDTH     (EW)
    ) dut (
        .clk          (clk),
        .rstna        (rstna),
        .ena          (ena),
        .q_in         (q_in),
        .pos          (pos),
        .dir          (dir),
        .locked       (locked),
        .tc           (tc),
        .err          (err),
        .period_count (period_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Next position of a bounce from (mpos, mdir): step one place, and if
    // that leaves the bus, step the other way instead.
    function automatic int bounce_next(output int ndir);
        int nxt;
        nxt  = mdir ? mpos - 1 : mpos + 1;
        ndir = mdir;
        if (nxt < 0)     begin nxt = 1;     ndir = 0; end
        if (nxt > N - 1) begin nxt = N - 2; ndir = 1; end
        return nxt;
    endfunction

    task automatic model(input bit rst, input bit en, input logic [N-1:0] q);
        exp_t e;
        int   v, idx, nxt, ndir, diff;
        bit   tcv, errv;
        v    = ($countones(q) == 1);
        idx  = v ? $clog2(q) : 0;
        tcv  = 0;
        errv = 0;
        if (rst) begin
            mstate = 0; mpos = 0; mdir = 1; mper = 0; merr = 0;
        end else if (en) begin
            if (mstate == 0) begin
                if (v) begin mpos = idx; mstate = 1; end
            end else if (mstate == 1) begin
                if (!v) mstate = 0;
                else begin
                    diff = idx - mpos;
                    if (diff == 1 || diff == -1) begin
                        mdir = (idx < mpos); mstate = 2;
                    end
                    mpos = idx;
                end
            end else begin
                nxt = bounce_next(ndir);
                if (v && idx == nxt) begin
                    mpos = nxt; mdir = ndir;
                    if (nxt == 0) begin
                        tcv  = 1;
                        mper = (mper + 1) % (1 << CW);
                    end
                end else begin
                    errv = 1;
                    if (ERRCNT && merr < (1 << EW) - 1) merr++;
                    if (v) begin mpos = idx; mstate = 1; end
                    else mstate = 0;
                end
            end
        end
        e.pos    = P'(mpos);
        e.dir    = mdir[0];
        e.locked = (mstate == 2);
        e.tc     = tcv;
        e.err    = errv;
        e.per    = CW'(mper);
        e.ec     = EW'(merr);
        sb.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit en, input logic [N-1:0] q);
        @(negedge clk);
        rstna = ~rst;
        ena   = en;
        q_in  = q;
        model(rst, en, q);
    endtask

    // A sample that continues the sequence the model is currently tracking.
    function automatic logic [N-1:0] clean_sample();
        int nxt, nd;
        logic [N-1:0] one;
        one = 1;
        if (mstate == 2)      nxt = bounce_next(nd);
        else if (mstate == 1) nxt = (mpos > 0) ? mpos - 1 : 1;
        else                  nxt = N - 1;
        return one << nxt;
    endfunction

    task automatic clean(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            drive(0, 1, clean_sample());
            for (int g = 0; g < gap; g++) drive(0, 0, N'($urandom));
        end
    endtask

    // Monitor: the DUT presents registered outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (pos !== e.pos || dir !== e.dir || locked !== e.locked ||
                    tc !== e.tc || err !== e.err || period_count !== e.per ||
                    err_count !== e.ec) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got pos=%0d dir=%0b locked=%0b tc=%0b err=%0b per=%0d ec=%0d, want pos=%0d dir=%0b locked=%0b tc=%0b err=%0b per=%0d ec=%0d",
                             $time, pos, dir, locked, tc, err, period_count, err_count,
                             e.pos, e.dir, e.locked, e.tc, e.err, e.per, e.ec);
                end
                n_checks++;
                if (tc === 1'b1 && err === 1'b1) begin
                    n_fail++;
                    $display("FAIL tc_err_exclusive @%0t: got tc=1 err=1, want not both", $time);
                end
            end
        end
    end

    initial begin
        int guard;
        logic [N-1:0] r;
        rstna = 1'b0;
        ena   = 1'b0;
        q_in  = '0;

        // Reset dominates an active strobe.
        repeat (3) drive(1, 1, 8'h80);
        drive(0, 1, 8'h80);
        drive(0, 1, 8'h40);
        // Full sweep down and back up, through the LSB.
        clean(14, 0);

        // Invalid sample while locked, then relock on 02,01.
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h02);
        drive(0, 1, 8'h01);
        clean(6, 0);

        // Reach position 4 moving right, then skip to 04.
        guard = 0;
        while (!(mstate == 2 && mpos == 4 && mdir == 1) && guard < 40) begin
            clean(1, 0);
            guard++;
        end
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h02);
        clean(4, 0);

        // Same sweep with strobe gaps.
        clean(16, 5);

        // Enough periods to wrap the narrow period counter.
        clean(14 * 5, 0);

        // Repeated violations to saturate the error counter.
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 8'h00);
            drive(0, 1, 8'h02);
            drive(0, 1, 8'h01);
            clean(3, 0);
        end

        // Multi-hot while locked, and a mid-sequence reset with ena high.
        drive(0, 1, 8'h03);
        clean(4, 0);
        drive(1, 1, 8'h10);
        clean(5, 0);

        // Randomised mix of clean, one-hot, zero, multi-hot and idle cycles.
        for (int k = 0; k < 3000; k++) begin
            r = '1;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: drive(0, 1, clean_sample());
                5:             drive(0, 1, r >> $urandom_range(0, N - 1) & (8'h01 << $urandom_range(0, N - 1)));
                6:             drive(0, 1, N'($urandom));
                7:             drive(0, 1, 8'h00);
                8:             drive(0, 0, N'($urandom));
                default:       drive(($urandom_range(0, 29) == 0), 1, clean_sample());
            endcase
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
